// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared peripheral bus.
// Grants one transaction at a time, muxes the owner onto the slave-side bus,
// routes the OR-combined slave response back to the owner only, and ends
// transactions to unmapped addresses with an error pulse after TIMEOUT cycles.
//
// Handshake: a master holds rd and/or wr (with addr/wrmask/data stable) until
// it sees a one-cycle rd_valid or wr_valid pulse; that pulse is the only
// completion. err accompanies the valid pulse when the arbiter itself ended
// the transaction. There is no back-pressure on the response path.
module bus_arbiter #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_m0_rd,
  input  logic        i_m0_wr,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_wrmask,
  input  logic [31:0] i_m0_data,
  output logic        o_m0_rd_valid,
  output logic        o_m0_wr_valid,
  output logic [31:0] o_m0_data,
  output logic        o_m0_err,
  input  logic        i_m1_rd,
  input  logic        i_m1_wr,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_wrmask,
  input  logic [31:0] i_m1_data,
  output logic        o_m1_rd_valid,
  output logic        o_m1_wr_valid,
  output logic [31:0] o_m1_data,
  output logic        o_m1_err,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_wrmask,
  output logic [31:0] o_bus_data,
  input  logic        i_bus_rd_valid,
  input  logic        i_bus_wr_valid,
  input  logic [31:0] i_bus_data,
  output logic [1:0]  o_grant,
  output logic        o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          own, own_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic        req0, req1, winner;
  logic        sel_rd, sel_wr, sel_req;
  logic [31:0] sel_addr, sel_data;
  logic [3:0]  sel_mask;
  logic        slave_vld, timeout_hit;
  logic        rd_done, wr_done, err_done;
  logic [31:0] rsp_data;

  assign o_dbg_state = state;

  // Request decode, owner input mux and arbitration winner.
  always_comb begin
    req0     = i_m0_rd | i_m0_wr;
    req1     = i_m1_rd | i_m1_wr;
    sel_rd   = own ? i_m1_rd     : i_m0_rd;
    sel_wr   = own ? i_m1_wr     : i_m0_wr;
    sel_addr = own ? i_m1_addr   : i_m0_addr;
    sel_mask = own ? i_m1_wrmask : i_m0_wrmask;
    sel_data = own ? i_m1_data   : i_m0_data;
    sel_req  = sel_rd | sel_wr;
    slave_vld   = i_bus_rd_valid | i_bus_wr_valid;
    // A slave response on the deadline cycle takes precedence over the error.
    timeout_hit = (state == BUSY) && (cnt == CNT_LAST) && !slave_vld && sel_req;
    if ((ROUND_ROBIN != 0) && req0 && req1) winner = ~last;
    else                                    winner = ~req0;
  end

  // Next-state, watchdog and slave-side bus outputs.
  always_comb begin
    state_nxt    = state;
    own_nxt      = own;
    last_nxt     = last;
    cnt_nxt      = cnt;
    o_bus_rd     = 1'b0;
    o_bus_wr     = 1'b0;
    o_bus_addr   = 32'h0;
    o_bus_wrmask = 4'h0;
    o_bus_data   = 32'h0;
    o_grant      = 2'b00;
    rd_done      = 1'b0;
    wr_done      = 1'b0;
    err_done     = 1'b0;
    rsp_data     = 32'h0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req0 || req1) begin
          state_nxt = BUSY;
          own_nxt   = winner;
          last_nxt  = winner;
        end
      end
      BUSY: begin
        o_bus_rd     = sel_rd & ~timeout_hit;
        o_bus_wr     = sel_wr & ~timeout_hit;
        o_bus_addr   = sel_addr;
        o_bus_wrmask = sel_mask;
        o_bus_data   = sel_data;
        o_grant      = own ? 2'b10 : 2'b01;
        rd_done      = i_bus_rd_valid | (timeout_hit & sel_rd);
        wr_done      = i_bus_wr_valid | (timeout_hit & ~sel_rd);
        err_done     = timeout_hit;
        rsp_data     = i_bus_rd_valid ? i_bus_data : 32'h0;
        // Completion, forced timeout or a withdrawn request all end the
        // transaction; a withdrawn request produces no pulse.
        if (slave_vld || timeout_hit || !sel_req) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the response to the owner only; the other master sees zeros.
  always_comb begin
    o_m0_rd_valid = rd_done  & ~own;
    o_m0_wr_valid = wr_done  & ~own;
    o_m0_err      = err_done & ~own;
    o_m0_data     = own ? 32'h0 : rsp_data;
    o_m1_rd_valid = rd_done  & own;
    o_m1_wr_valid = wr_done  & own;
    o_m1_err      = err_done & own;
    o_m1_data     = own ? rsp_data : 32'h0;
  end

  // State, owner, priority and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter for the shared SoC peripheral bus (RAM, timer, GPI, GPO, GPIO slaves with OR-combined responses). Master 0 is the CPU and master 1 is a second bus master (DMA or debug loader). The block grants one transaction at a time, muxes the granted master onto the single slave-side bus and routes the slave response back to that master only. A watchdog terminates transactions to unmapped addresses, which no slave acknowledges.

Parameters:
TIMEOUT, 255, cycles in BUSY without slave response before a forced error completion (1..65535).
ROUND_ROBIN, 1, 1 = alternate priority after each grant; 0 = fixed priority, m0 always wins.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_m0_rd  in  1  m0 read request, held until completion
i_m0_wr  in  1  m0 write request, held until completion
i_m0_addr  in  32  m0 byte address
i_m0_wrmask  in  4  m0 byte write enables
i_m0_data  in  32  m0 write data
o_m0_rd_valid  out  1  m0 read complete, 1-cycle pulse
o_m0_wr_valid  out  1  m0 write complete, 1-cycle pulse
o_m0_data  out  32  m0 read data, valid with o_m0_rd_valid
o_m0_err  out  1  m0 timeout completion, 1-cycle pulse
i_m1_* / o_m1_*  same set as m0, for master 1
o_bus_rd  out  1  slave-side read
o_bus_wr  out  1  slave-side write
o_bus_addr  out  32  slave-side address
o_bus_wrmask  out  4  slave-side byte enables
o_bus_data  out  32  slave-side write data
i_bus_rd_valid  in  1  OR of slave read-valids
i_bus_wr_valid  in  1  OR of slave write-valids
i_bus_data  in  32  OR of slave read data
o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 0 when idle

Behaviour:
- State machine: IDLE, BUSY. A registered owner bit (own) and a last-granted bit (last) are kept.
- Request per master: req_k = i_mk_rd | i_mk_wr.
- IDLE behaviour:
  - All o_bus_* are 0, so slaves never see stray data on the OR bus.
  - If any req_k is set, go to BUSY next cycle with own set to the winner.
  - Winner with ROUND_ROBIN=1 and both requesting: the master not equal to last.
  - Winner with ROUND_ROBIN=0: m0 if req_0, otherwise m1.
  - last is updated to the winner.
- BUSY behaviour:
  - o_bus_* equal the owner's inputs combinationally, and o_grant is one-hot of own.
  - The watchdog counter increments each cycle.
- Completion:
  - In the cycle i_bus_rd_valid or i_bus_wr_valid is high in BUSY, forward it combinationally to the owner's o_mk_rd_valid / o_mk_wr_valid.
  - In that cycle o_mk_data = i_bus_data.
  - Next state is IDLE and the counter clears.
  - The earliest re-grant is the cycle after IDLE, so there is one idle cycle between transactions.
- Non-owner outputs (valid, data, err) are always 0. Owner o_mk_data is 0 outside its rd_valid cycle.
- Slave responses arriving in IDLE are ignored and never forwarded.
- Timeout:
  - When the counter reaches TIMEOUT-1 with no slave valid, the arbiter completes the transaction itself that cycle.
  - It pulses the owner's valid (rd_valid if the owner's rd is set, else wr_valid) together with o_mk_err=1 and o_mk_data=0.
  - o_bus_rd and o_bus_wr are forced to 0 in that cycle. Next state is IDLE.
  - If a slave valid arrives on that same cycle, the slave response wins and err=0.
- Request withdrawal: if the owner drops both rd and wr in BUSY (illegal master behaviour), return to IDLE next cycle with no response pulse. o_bus_rd and o_bus_wr follow the owner inputs and are therefore 0 in that cycle.
- rd and wr both high from one master: forwarded unchanged. Completion is on whichever valid the slave returns.
- Counter width is clog2(TIMEOUT+1). The counter saturates, never wraps.
- Reset (any state, including mid-transaction):
  - State becomes IDLE, own=0, last=1 (so m0 has first priority), counter=0.
  - All outputs become 0. An in-flight transaction is dropped with no response.

Test Plan:
- m0 reads 0x0000_0010, slave returns rd_valid with 0x1234_5678 two cycles after the grant:
  - o_bus_rd=1 and o_bus_addr=0x10 from grant+0.
  - o_m0_rd_valid=1 with o_m0_data=0x12345678 for one cycle.
  - o_grant returns to 0 the next cycle.
- m0 and m1 both request writes continuously, ROUND_ROBIN=1, slave acks each one cycle after grant:
  - Grants go m0, m1, m0, m1.
  - o_m1_* stay 0 during m0 ownership and vice versa.
- Same stimulus with ROUND_ROBIN=0: m0 gets every grant and m1 never wins while m0 keeps requesting.
- m1 reads unmapped 0xF000_0000, no slave response, TIMEOUT=8:
  - On the 8th BUSY cycle, o_m1_rd_valid=1, o_m1_err=1, o_m1_data=0, o_bus_rd=0.
  - Then IDLE.
- Timeout cycle coincides with i_bus_rd_valid=1 and data 0xAA: o_m0_rd_valid=1, data 0xAA, o_m0_err=0.
- rst pulsed during an m1 BUSY transaction:
  - Next cycle all outputs are 0 and no valid is issued to m1.
  - With m0 and m1 then both requesting, m0 is granted first.
